// File: rtl/rv_burst_tx.sv
// rv_burst_tx: accepts a burst command and emits an incrementing or constant data burst on a srdy/rrdy stream.
module rv_burst_tx #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_srdy,
   output logic              cmd_rrdy,
   input  logic [DATA_W-1:0] cmd_start,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              cmd_mode,
   output logic              out_srdy,
   input  logic              out_rrdy,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic [15:0]       beats_sent
);
   typedef enum logic {IDLE, SEND} state_t;
   state_t state, state_nx;
   logic [LEN_W:0] remaining;
   logic mode;
   logic cmd_xfer, out_xfer;
   assign cmd_rrdy = (state == IDLE);
   assign out_srdy = (state == SEND);
   assign busy     = (state == SEND);
   assign out_last = out_srdy && (remaining == {{LEN_W{1'b0}}, 1'b1});
   assign cmd_xfer = cmd_srdy && cmd_rrdy;
   assign out_xfer = out_srdy && out_rrdy;
   always_comb begin
      state_nx = state;
      if (cmd_xfer) state_nx = SEND;
      else if (out_xfer && out_last) state_nx = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         out_data   <= '0;
         remaining  <= '0;
         mode       <= 1'b0;
         beats_sent <= '0;
      end else begin
         state <= state_nx;
         if (cmd_xfer) begin
            out_data  <= cmd_start;
            mode      <= cmd_mode;
            remaining <= (cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cmd_len};
         end else if (out_xfer) begin
            out_data   <= mode ? out_data : out_data + 1'b1;
            remaining  <= remaining - 1'b1;
            beats_sent <= (beats_sent == 16'hFFFF) ? beats_sent : beats_sent + 16'd1;
         end
      end
   end
endmodule
